// File: rtl/rast_feeder_pkg.sv
// Shared types and helpers for the rasterizer triangle feeder.
//   vert_t / tri_t / verts_t / color_t : fixed-point vertex and color containers
//   prim_t         : one buffered primitive (up to 4 verts, color, quad flag)
//   split_state_t  : which triangle of the head primitive is being presented
//   msaa_decode()  : maps an MSAA sample count to subsample one-hot and log2 width
//   SCREEN_DEFAULT : 512.0 in SIGFIG.RADIX fixed point
package rast_feeder_pkg;

  localparam int SIGFIG   = 24;
  localparam int RADIX    = 10;
  localparam int IN_VERTS = 4;
  localparam int AXIS     = 3;
  localparam int COLORS   = 3;

  typedef logic [AXIS-1:0][SIGFIG-1:0]   vert_t;   // signed per axis
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;  // unsigned per channel
  typedef vert_t [2:0]                   tri_t;    // index 0 = first vertex
  typedef vert_t [IN_VERTS-1:0]          verts_t;

  typedef struct packed {
    verts_t verts;
    color_t color;
    logic   quad;     // 1 = four vertices, emitted as two triangles
  } prim_t;

  typedef enum logic {
    EMIT0 = 1'b0,     // presenting (v0,v1,v2)
    EMIT1 = 1'b1      // presenting (v0,v2,v3) of a quad
  } split_state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] sub_sample;
    logic [1:0] ss_w_lg2;
  } msaa_cfg_t;

  localparam logic [SIGFIG-1:0] SCREEN_DEFAULT = SIGFIG'(32'd512 << RADIX);
  localparam msaa_cfg_t         MSAA_DEFAULT   = '{1'b1, 4'b0100, 2'd1};

  function automatic msaa_cfg_t msaa_decode(input logic [6:0] msaa);
    msaa_cfg_t r;
    r = '{1'b0, 4'b0100, 2'd1};
    case (msaa)
      7'd1:    r = '{1'b1, 4'b1000, 2'd0};
      7'd4:    r = '{1'b1, 4'b0100, 2'd1};
      7'd16:   r = '{1'b1, 4'b0010, 2'd2};
      7'd64:   r = '{1'b1, 4'b0001, 2'd3};
      default: r = '{1'b0, 4'b0100, 2'd1};
    endcase
    return r;
  endfunction

  // First triangle of any primitive.
  function automatic tri_t tri_first(input verts_t v);
    tri_t t;
    t[0] = v[0];
    t[1] = v[1];
    t[2] = v[2];
    return t;
  endfunction

  // Second triangle of a quad: fan around v0.
  function automatic tri_t tri_second(input verts_t v);
    tri_t t;
    t[0] = v[0];
    t[1] = v[2];
    t[2] = v[3];
    return t;
  endfunction

endpackage

// File: rtl/rast_tri_feeder_if.sv
// Primitive input stream and triangle output stream of the feeder.
//   in_*           : primitive offer (valid/ready), vertex data, color, last flag
//   tri_R10S etc.  : triangle presented to the rasterizer
//   halt_RnnnnL    : 1 = rasterizer accepts this cycle
// master = environment (producer + rasterizer), slave = the feeder.
interface rast_tri_feeder_if;
  import rast_feeder_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_num_verts;
  verts_t     in_tri;
  color_t     in_color;
  logic       in_last;

  tri_t       tri_R10S;
  color_t     color_R10U;
  logic       validTri_R10H;
  logic       halt_RnnnnL;

  modport master (
    output in_valid, in_num_verts, in_tri, in_color, in_last, halt_RnnnnL,
    input  in_ready, tri_R10S, color_R10U, validTri_R10H
  );

  modport slave (
    input  in_valid, in_num_verts, in_tri, in_color, in_last, halt_RnnnnL,
    output in_ready, tri_R10S, color_R10U, validTri_R10H
  );
endinterface

// File: rtl/rast_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and a one-ahead peek.
//   clk, rst       : clock, synchronous active-high reset (flushes pointers)
//   wr_en, wr_data : push (ignored when full)
//   rd_en          : pop head (ignored when empty)
//   rd_data        : current head
//   rd_data_next   : entry behind the head (valid when count >= 2)
//   full, empty, count
// Pointers carry one extra wrap bit so full/empty are distinguishable.
module rast_sync_fifo
  import rast_feeder_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = prim_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  T                         wr_data,
  input  logic                     rd_en,
  output T                         rd_data,
  output T                         rd_data_next,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  rd_idx_next;
  logic           do_wr;
  logic           do_rd;

  assign count       = wr_ptr_reg - rd_ptr_reg;
  assign full        = (count == (AW+1)'(DEPTH));
  assign empty       = (count == '0);
  assign do_wr       = wr_en & ~full;
  assign do_rd       = rd_en & ~empty;
  assign rd_idx      = rd_ptr_reg[AW-1:0];
  assign rd_idx_next = rd_idx + AW'(1);
  assign rd_data      = mem[rd_idx];
  assign rd_data_next = mem[rd_idx_next];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/rast_tri_feeder.sv
// Triangle front-end: buffers 3/4-vertex primitives, splits quads into two
// triangles and presents them to the rasterizer under halt backpressure.
//   clk, rst                     : clock, synchronous active-high reset
//   bus (slave)                  : primitive input stream + triangle output stream
//   cfg_we, cfg_screen, cfg_msaa : config write (only taken while fully idle)
//   screen_RnnnnS                : active screen w,h
//   subSample_RnnnnU, ss_w_lg2_RnnnnS : decoded MSAA setting
//   err_verts, cfg_err, done     : sticky status flags
// The head primitive stays in the FIFO while any of its triangles is on the
// output; it is popped by the fire of its last triangle, and the following
// entry is loaded in the same cycle via the FIFO's one-ahead peek.
module rast_tri_feeder
  import rast_feeder_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  rast_tri_feeder_if.slave         bus,
  input  logic                     cfg_we,
  input  logic [1:0][SIGFIG-1:0]   cfg_screen,
  input  logic [6:0]               cfg_msaa,
  output logic [1:0][SIGFIG-1:0]   screen_RnnnnS,
  output logic [3:0]               subSample_RnnnnU,
  output logic [1:0]               ss_w_lg2_RnnnnS,
  output logic                     err_verts,
  output logic                     cfg_err,
  output logic                     done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  // FIFO side
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wr;
  logic          fifo_rd;
  logic [CW-1:0] fifo_count;
  prim_t         head;
  prim_t         head_next;
  prim_t         wr_prim;
  logic          accept;
  logic          legal;

  assign accept       = bus.in_valid & ~fifo_full;
  assign legal        = (bus.in_num_verts == 3'd3) || (bus.in_num_verts == 3'd4);
  assign fifo_wr      = accept & legal;
  assign wr_prim      = '{verts: bus.in_tri, color: bus.in_color,
                          quad: (bus.in_num_verts == 3'd4)};
  assign bus.in_ready = ~fifo_full;

  rast_sync_fifo #(.DEPTH(DEPTH), .T(prim_t)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (fifo_wr),
    .wr_data      (wr_prim),
    .rd_en        (fifo_rd),
    .rd_data      (head),
    .rd_data_next (head_next),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .count        (fifo_count)
  );

  // Split FSM and output register
  split_state_t state_reg, state_next;
  tri_t         tri_reg, tri_next;
  color_t       color_reg, color_next;
  logic         valid_reg, valid_next;
  logic         fire;

  assign fire = valid_reg & bus.halt_RnnnnL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMIT0;
      tri_reg   <= '0;
      color_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      tri_reg   <= tri_next;
      color_reg <= color_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tri_next   = tri_reg;
    color_next = color_reg;
    valid_next = valid_reg;
    fifo_rd    = 1'b0;
    if (!valid_reg) begin
      // Nothing presented: the head (if any) has not been shown yet.
      if (!fifo_empty) begin
        valid_next = 1'b1;
        state_next = EMIT0;
        tri_next   = tri_first(head.verts);
        color_next = head.color;
      end
    end else if (fire) begin
      if (state_reg == EMIT0 && head.quad) begin
        state_next = EMIT1;
        tri_next   = tri_second(head.verts);
      end else begin
        fifo_rd    = 1'b1;
        state_next = EMIT0;
        // Entry behind the head must already be stored; a push landing this
        // same edge is picked up one cycle later.
        if (fifo_count >= CW'(2)) begin
          tri_next   = tri_first(head_next.verts);
          color_next = head_next.color;
        end else begin
          valid_next = 1'b0;
        end
      end
    end
  end

  assign bus.tri_R10S      = tri_reg;
  assign bus.color_R10U    = color_reg;
  assign bus.validTri_R10H = valid_reg;

  // Config and error flags
  logic [1:0][SIGFIG-1:0] screen_reg;
  logic [3:0]             sub_sample_reg;
  logic [1:0]             ss_lg2_reg;
  logic                   cfg_err_reg;
  logic                   err_verts_reg;
  msaa_cfg_t              msaa_dec;
  logic                   cfg_idle;

  assign msaa_dec = msaa_decode(cfg_msaa);
  assign cfg_idle = fifo_empty & ~valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      screen_reg     <= {SCREEN_DEFAULT, SCREEN_DEFAULT};
      sub_sample_reg <= MSAA_DEFAULT.sub_sample;
      ss_lg2_reg     <= MSAA_DEFAULT.ss_w_lg2;
      cfg_err_reg    <= 1'b0;
      err_verts_reg  <= 1'b0;
    end else begin
      if (cfg_we) begin
        if (cfg_idle && msaa_dec.ok) begin
          screen_reg     <= cfg_screen;
          sub_sample_reg <= msaa_dec.sub_sample;
          ss_lg2_reg     <= msaa_dec.ss_w_lg2;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end
      if (accept && !legal) err_verts_reg <= 1'b1;
    end
  end

  assign screen_RnnnnS    = screen_reg;
  assign subSample_RnnnnU = sub_sample_reg;
  assign ss_w_lg2_RnnnnS  = ss_lg2_reg;
  assign cfg_err          = cfg_err_reg;
  assign err_verts        = err_verts_reg;

  // End-of-stream drain detection
  logic          armed_reg;
  logic [DW-1:0] drain_cnt_reg;
  logic          done_reg;
  logic          drain_idle;

  assign drain_idle = armed_reg & fifo_empty & ~valid_reg & bus.halt_RnnnnL;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_reg     <= 1'b0;
      drain_cnt_reg <= '0;
      done_reg      <= 1'b0;
    end else begin
      if (accept && bus.in_last) armed_reg <= 1'b1;
      if (drain_idle) begin
        if (drain_cnt_reg != DW'(DRAIN_CYCLES)) drain_cnt_reg <= drain_cnt_reg + DW'(1);
        if (drain_cnt_reg == DW'(DRAIN_CYCLES - 1)) done_reg <= 1'b1;
      end else begin
        drain_cnt_reg <= '0;
      end
    end
  end

  assign done = done_reg;
endmodule

// File: tb/tb_rast_tri_feeder.sv
module tb_rast_tri_feeder;
  import rast_feeder_pkg::*;

  localparam int DEPTH = 4;
  localparam int DRAIN = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rast_tri_feeder_if bus();

  logic                   cfg_we;
  logic [1:0][SIGFIG-1:0] cfg_screen;
  logic [6:0]             cfg_msaa;
  logic [1:0][SIGFIG-1:0] screen;
  logic [3:0]             sub_sample;
  logic [1:0]             ss_lg2;
  logic                   err_verts, cfg_err, done;

  rast_tri_feeder #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .cfg_we           (cfg_we),
    .cfg_screen       (cfg_screen),
    .cfg_msaa         (cfg_msaa),
    .screen_RnnnnS    (screen),
    .subSample_RnnnnU (sub_sample),
    .ss_w_lg2_RnnnnS  (ss_lg2),
    .err_verts        (err_verts),
    .cfg_err          (cfg_err),
    .done             (done)
  );

  typedef struct packed {
    tri_t   t;
    color_t c;
  } exp_t;

  typedef struct {
    logic [6:0]        msaa;
    logic [SIGFIG-1:0] w, h;
    logic [3:0]        exp_ss;
    logic [1:0]        exp_lg2;
    logic [SIGFIG-1:0] exp_w, exp_h;
    logic              exp_err;
  } cfg_vec_t;

  exp_t     exp_q[$];
  int       fire_cyc[$];
  int       errors = 0;
  int       checks = 0;
  int       cyc = 0;
  int       rise_cyc = 0;
  cfg_vec_t cfg_tab[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic tri_t pick(input verts_t v, input int a, input int b, input int c);
    tri_t t;
    t[0] = v[a];
    t[1] = v[b];
    t[2] = v[c];
    return t;
  endfunction

  // Output monitor: every fire pops one expectation; outputs must hold while stalled.
  initial begin
    tri_t   prev_tri;
    color_t prev_col;
    logic   prev_hold;
    logic   prev_valid;
    exp_t   e;
    prev_hold  = 1'b0;
    prev_valid = 1'b0;
    prev_tri   = '0;
    prev_col   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_hold  = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 256'(bus.validTri_R10H), 256'(1'b1));
          check("hold_tri", 256'(bus.tri_R10S), 256'(prev_tri));
          check("hold_color", 256'(bus.color_R10U), 256'(prev_col));
        end
        if (bus.validTri_R10H && !prev_valid) rise_cyc = cyc;
        if (bus.validTri_R10H && bus.halt_RnnnnL) begin
          fire_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tri: got %0h expected none", bus.tri_R10S);
          end else begin
            e = exp_q.pop_front();
            $display("tri out cyc=%0d tri=%0h color=%0h", cyc, bus.tri_R10S, bus.color_R10U);
            check("tri", 256'(bus.tri_R10S), 256'(e.t));
            check("color", 256'(bus.color_R10U), 256'(e.c));
          end
        end
        prev_hold  = bus.validTri_R10H & ~bus.halt_RnnnnL;
        prev_valid = bus.validTri_R10H;
        prev_tri   = bus.tri_R10S;
        prev_col   = bus.color_R10U;
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [2:0] nv, input logic last, output int acc_cyc);
    verts_t v;
    color_t c;
    logic   rdy;
    int     budget;
    for (int i = 0; i < IN_VERTS; i++)
      for (int j = 0; j < AXIS; j++)
        v[i][j] = SIGFIG'($urandom());
    for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'($urandom());
    bus.in_valid     = 1'b1;
    bus.in_num_verts = nv;
    bus.in_tri       = v;
    bus.in_color     = c;
    bus.in_last      = last;
    budget  = 0;
    acc_cyc = 0;
    rdy     = 1'b0;
    do begin
      @(negedge clk);
      rdy     = bus.in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 200);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got in_ready=0 expected accept within 200 cycles");
    end else begin
      $display("push cyc=%0d nv=%0d last=%0b", acc_cyc, nv, last);
      if (nv == 3'd3 || nv == 3'd4) exp_q.push_back('{pick(v, 0, 1, 2), c});
      if (nv == 3'd4)               exp_q.push_back('{pick(v, 0, 2, 3), c});
    end
  endtask

  // Returns at the first negedge where the scoreboard is empty and no triangle is shown.
  task automatic wait_drain();
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      budget++;
      if (exp_q.size() == 0 && !bus.validTri_R10H) break;
      if (budget > 300) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        break;
      end
    end
  endtask

  task automatic cfg_write(input logic [6:0] m, input logic [SIGFIG-1:0] w, input logic [SIGFIG-1:0] h);
    cfg_we        = 1'b1;
    cfg_msaa      = m;
    cfg_screen[0] = w;
    cfg_screen[1] = h;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, n0;
    int dummy;
    cfg_tab[0] = '{7'd16, 24'h012345, 24'h006789, 4'b0010, 2'd2, 24'h012345, 24'h006789, 1'b0};
    cfg_tab[1] = '{7'd64, 24'h0A0000, 24'h050000, 4'b0001, 2'd3, 24'h0A0000, 24'h050000, 1'b0};
    cfg_tab[2] = '{7'd1,  24'h001000, 24'h002000, 4'b1000, 2'd0, 24'h001000, 24'h002000, 1'b0};
    cfg_tab[3] = '{7'd8,  24'h0FFFFF, 24'h0EEEEE, 4'b1000, 2'd0, 24'h001000, 24'h002000, 1'b1};
    cfg_tab[4] = '{7'd4,  24'h080000, 24'h040000, 4'b0100, 2'd1, 24'h080000, 24'h040000, 1'b1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_num_verts = 3'd3;
    bus.in_tri = '0;
    bus.in_color = '0;
    bus.in_last = 1'b0;
    bus.halt_RnnnnL = 1'b1;
    cfg_we = 1'b0;
    cfg_msaa = 7'd0;
    cfg_screen = '0;
    reset_dut();

    // 1. reset state
    @(negedge clk);
    check("rst_screen_w", 256'(screen[0]), 256'(24'h080000));
    check("rst_screen_h", 256'(screen[1]), 256'(24'h080000));
    check("rst_subsample", 256'(sub_sample), 256'(4'b0100));
    check("rst_ss_lg2", 256'(ss_lg2), 256'(2'd1));
    check("rst_valid", 256'(bus.validTri_R10H), 256'(1'b0));
    check("rst_in_ready", 256'(bus.in_ready), 256'(1'b1));
    check("rst_tri", 256'(bus.tri_R10S), 256'(0));
    check("rst_flags", 256'({err_verts, cfg_err, done}), 256'(3'b000));

    // 2. three triangles back to back
    @(posedge clk); #1;
    n0 = fire_cyc.size();
    push(3'd3, 1'b0, a0);
    push(3'd3, 1'b0, a1);
    push(3'd3, 1'b0, a2);
    wait_drain();
    check("latency", 256'(rise_cyc - a0), 256'(2));
    if (fire_cyc.size() >= n0 + 3)
      check("back_to_back", 256'(fire_cyc[n0+2] - fire_cyc[n0]), 256'(2));
    else begin
      checks++; errors++;
      $display("FAIL fire_count: got %0d expected 3", fire_cyc.size() - n0);
    end

    // 3. quad split into two consecutive triangles
    @(posedge clk); #1;
    n0 = fire_cyc.size();
    push(3'd4, 1'b0, a0);
    wait_drain();
    if (fire_cyc.size() >= n0 + 2)
      check("quad_consecutive", 256'(fire_cyc[n0+1] - fire_cyc[n0]), 256'(1));
    else begin
      checks++; errors++;
      $display("FAIL quad_fires: got %0d expected 2", fire_cyc.size() - n0);
    end

    // 4. backpressure fills the FIFO; order preserved after release
    @(posedge clk); #1 bus.halt_RnnnnL = 1'b0;
    for (int i = 0; i < DEPTH; i++) push((i == 1) ? 3'd4 : 3'd3, 1'b0, a0);
    @(negedge clk);
    check("full_in_ready", 256'(bus.in_ready), 256'(1'b0));
    check("full_valid", 256'(bus.validTri_R10H), 256'(1'b1));
    @(posedge clk); #1;
    fork
      begin
        automatic int d;
        push(3'd3, 1'b0, d);
      end
    join_none
    repeat (5) @(posedge clk);
    #1 bus.halt_RnnnnL = 1'b1;
    wait fork;
    wait_drain();

    // 5. config table while idle
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      cfg_write(cfg_tab[i].msaa, cfg_tab[i].w, cfg_tab[i].h);
      $display("cfg msaa=%0d ss=%b lg2=%0d err=%0b", cfg_tab[i].msaa, sub_sample, ss_lg2, cfg_err);
      check("cfg_ss", 256'(sub_sample), 256'(cfg_tab[i].exp_ss));
      check("cfg_lg2", 256'(ss_lg2), 256'(cfg_tab[i].exp_lg2));
      check("cfg_w", 256'(screen[0]), 256'(cfg_tab[i].exp_w));
      check("cfg_h", 256'(screen[1]), 256'(cfg_tab[i].exp_h));
      check("cfg_err", 256'(cfg_err), 256'(cfg_tab[i].exp_err));
      @(posedge clk); #1;
    end

    // 5b. config write while busy is rejected; then reset mid-stream
    reset_dut();
    bus.halt_RnnnnL = 1'b0;
    push(3'd3, 1'b0, a0);
    cfg_write(7'd16, 24'h000100, 24'h000200);
    check("busy_cfg_err", 256'(cfg_err), 256'(1'b1));
    check("busy_cfg_ss", 256'(sub_sample), 256'(4'b0100));
    check("busy_cfg_w", 256'(screen[0]), 256'(24'h080000));
    check("busy_valid", 256'(bus.validTri_R10H), 256'(1'b1));
    reset_dut();
    bus.halt_RnnnnL = 1'b1;
    @(negedge clk);
    check("midrst_valid", 256'(bus.validTri_R10H), 256'(1'b0));
    check("midrst_in_ready", 256'(bus.in_ready), 256'(1'b1));
    check("midrst_tri", 256'(bus.tri_R10S), 256'(0));
    check("midrst_cfg_err", 256'(cfg_err), 256'(1'b0));
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_out", 256'(bus.validTri_R10H), 256'(1'b0));
    end

    // 6. illegal vertex count, then end-of-stream drain
    @(posedge clk); #1;
    push(3'd5, 1'b0, a0);
    @(negedge clk);
    check("err_verts", 256'(err_verts), 256'(1'b1));
    repeat (3) begin
      @(negedge clk);
      check("err_no_out", 256'(bus.validTri_R10H), 256'(1'b0));
    end
    @(posedge clk); #1;
    push(3'd3, 1'b1, a0);
    wait_drain();                      // this negedge is idle cycle 1
    for (int k = 2; k <= DRAIN + 1; k++) begin
      @(negedge clk);
      if (k == DRAIN)     check("done_early", 256'(done), 256'(1'b0));
      if (k == DRAIN + 1) check("done_set", 256'(done), 256'(1'b1));
    end
    @(posedge clk); #1;
    push(3'd3, 1'b0, a0);
    wait_drain();
    check("done_sticky", 256'(done), 256'(1'b1));

    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
